tc_timer: RTL
=============

// Module: tc_timer
// PURPOSE
//  Memory-mapped down-counting timer on the CPU peripheral bus. Consumes the store
//  address/data the CPU drives out of its M stage; returns read data to the CPU's
//  peripheral-read input. Drives an interrupt line into CPU HWint (int_time0/int_time1).
//  Two instances are built: one per timer interrupt. Decode to this block is done outside it.
// PARAMETERS
//  (none) register map and widths are fixed by header constants
// PORTS
//  clk     in   1   system clock; all state updates on rising edge
//  reset   in   1   asynchronous, active-high; clears all state immediately
//  sel     in   1   bus select, from the external address decoder
//  we      in   1   word write strobe, qualified by sel
//  addr    in   2   word offset (bus addr[3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=unmapped
//  wdata   in   32  write data
//  rdata   out  32  read data, combinational on addr (reads ignore sel)
//  irq     out  1   interrupt request = CTRL.IM & int_flag
// BEHAVIOUR
//  Registers:
//   CTRL[3:0] = {IM, MODE[1:0], EN}; bits [31:4] are read as 0 and written nowhere.
//   PRESET[31:0]: read/write. COUNT[31:0]: read-only; writes to it are ignored.
//   addr==3: reads return 0; writes to it are ignored.
//  MODE encodings: 00 one-shot, 01 auto-reload; 1x behaves as 00.
//  Reset values: CTRL=0, PRESET=0, COUNT=0, state=IDLE, int_flag=0, irq=0, rdata=0 at addr 0.
//  A CTRL write (sel&we&addr==0) clears int_flag. This is the interrupt acknowledge.
//  FSM states: IDLE, LOAD, CNT, INT.
//   IDLE: if EN -> LOAD.
//   LOAD: COUNT<=PRESET -> CNT.
//   CNT : if !EN -> IDLE, and COUNT holds its value.
//         else if COUNT>1, COUNT<=COUNT-1.
//         else (COUNT is 0 or 1): COUNT<=0, int_flag<=1 -> INT.
//   INT : one-shot: EN<=0, int_flag is kept -> IDLE.
//         auto-reload: int_flag<=0 -> IDLE, which reloads because EN is still 1.
//  Timing for PRESET=N>=1, EN written at edge t:
//   LOAD at t+1; COUNT=N after t+2; COUNT=0 and INT after t+N+2.
//   irq is visible from edge t+N+2.
//   Auto-reload period is N+3 cycles, with irq high for exactly 1 cycle.
//   PRESET=0 behaves like PRESET=1.
//  Simultaneous events:
//   A CPU CTRL write and the FSM's EN clear in INT on the same edge: the CPU write wins,
//   and int_flag still sets/clears per the rules above, with the write's clear taking priority.
//   A PRESET write during CNT does not disturb COUNT; it takes effect at the next LOAD.
//   Clearing EN in LOAD or INT: the current transition completes, then CNT/IDLE sees EN=0.
//  Reset mid-count returns to IDLE with COUNT=0 asynchronously. Any pending irq drops at once.
//  Arithmetic: 32-bit unsigned decrement with no wrap. COUNT never goes below 0.
// STRUCTURE
//  Shared header const.v holds `defines for:
//   - register offsets TC_CTRL/TC_PRESET/TC_COUNT
//   - CTRL bit positions EN/MODE/IM
//   - mode codes
//   - 2-bit FSM state codes
//  Single module. The register file, FSM and read mux are all inline; no sub-module is warranted.
// TESTING
//  1. Reset during CNT with COUNT=5 -> COUNT=0, state IDLE, irq=0 before the next edge.
//  2. One-shot: PRESET=3, CTRL=0b1001 at edge t -> COUNT 3,2,1,0;
//     irq rises at t+5 and stays high; EN reads 0; a CTRL write of 0 drops irq.
//  3. Auto-reload: PRESET=2, CTRL=0b1011 -> irq is a 1-cycle pulse every 5 cycles;
//     COUNT reload is observed each period.
//  4. IM=0 with MODE=00, PRESET=1 -> int_flag sets but irq stays 0;
//     a later write of IM=1 via CTRL clears the flag, so irq stays 0.
//  5. PRESET=0 -> irq at t+3. Writes to COUNT and addr 3 leave COUNT unchanged and read 0.
//  6. Clear EN mid-count at COUNT=7 -> COUNT frozen at 7, state IDLE;
//     re-enable -> reload from PRESET.

Source files
------------

// File: rtl/tc_timer_pkg.sv
// Shared constants for the memory-mapped down-counting timer: register offsets,
// CTRL bit positions, mode codes and FSM state encoding.
package tc_timer_pkg;

  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_AUTO = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  // Only 01 reloads; 00 and both 1x encodings act as one-shot.
  function automatic logic is_auto(input logic [1:0] mode);
    return mode == MODE_AUTO;
  endfunction

endpackage

// File: rtl/tc_timer.sv
// Down-counting peripheral timer: CTRL/PRESET/COUNT register file, four-state
// count FSM and combinational read mux, with a maskable interrupt output.
module tc_timer
  import tc_timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        int_flag;
  state_t      state;

  state_t      state_nxt;
  logic [31:0] count_nxt;
  logic        flag_set;
  logic        flag_clr;
  logic        en_clr;

  logic        ctrl_wr;
  logic        preset_wr;
  logic        en;
  logic        wdata_unused;

  assign ctrl_wr      = sel & we & (addr == TC_CTRL);
  assign preset_wr    = sel & we & (addr == TC_PRESET);
  assign en           = ctrl[CTRL_EN];
  assign wdata_unused = ^wdata[31:4];

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    flag_set  = 1'b0;
    flag_clr  = 1'b0;
    en_clr    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        count_nxt = preset;
        state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_nxt = ST_IDLE;
        end else if (count > 32'd1) begin
          count_nxt = count - 32'd1;
        end else begin
          // A zero preset lands here too, so it fires like a preset of one.
          count_nxt = 32'd0;
          flag_set  = 1'b1;
          state_nxt = ST_INT;
        end
      end
      ST_INT: begin
        if (is_auto(ctrl[CTRL_MODE_HI:CTRL_MODE_LO])) flag_clr = 1'b1;
        else                                          en_clr   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= 32'd0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // A CPU CTRL write overrides the FSM's EN clear and acknowledges the interrupt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl     <= 4'd0;
      preset   <= 32'd0;
      int_flag <= 1'b0;
    end else begin
      if (ctrl_wr)     ctrl          <= wdata[3:0];
      else if (en_clr) ctrl[CTRL_EN] <= 1'b0;

      if (preset_wr) preset <= wdata;

      if (ctrl_wr)       int_flag <= 1'b0;
      else if (flag_set) int_flag <= 1'b1;
      else if (flag_clr) int_flag <= 1'b0;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr)
      TC_CTRL:   rdata = {28'd0, ctrl};
      TC_PRESET: rdata = preset;
      TC_COUNT:  rdata = count;
      default:   rdata = 32'd0;
    endcase
  end

  assign irq = ctrl[CTRL_IM] & int_flag;

endmodule
